// File: rtl/mul_iter.sv
// mul_iter: iterative shift-add multiplier, one partial product per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand request
//   in_ready   operands accepted (IDLE only, low while rst is high)
//   a, b       WIDTH-bit multiplicand / multiplier
//   is_signed  1: operands and product are two's complement, 0: unsigned
//   out_valid  p holds a completed product
//   out_ready  consumer accepts p
//   p          2*WIDTH-bit registered product
//
// States:
//   state  | meaning
//   IDLE   | waiting for operands, in_ready high
//   CALC   | one shift-add iteration per cycle, WIDTH iterations
//   DONE   | product valid in p, waiting for out_ready

module mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [WIDTH-1:0]   mag_a_q, mag_a_d;
  logic               neg_q, neg_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               out_valid_q, out_valid_d;

  logic               a_neg, b_neg;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   shifted;
  logic [2*WIDTH-1:0] prod;

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign p         = p_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mplr_d      = mplr_q;
    mag_a_d     = mag_a_q;
    neg_d       = neg_q;
    count_d     = count_q;
    p_d         = p_q;
    out_valid_d = out_valid_q;

    a_neg = is_signed && a[WIDTH-1];
    b_neg = is_signed && b[WIDTH-1];

    sum     = acc_q + {1'b0, (mplr_q[0] ? mag_a_q : '0)};
    shifted = {sum, mplr_q} >> 1;
    // acc never exceeds 2^WIDTH-1 after the shift, so the top bit is always 0
    prod    = shifted[2*WIDTH-1:0];

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude
          mag_a_d = a_neg ? -a : a;
          mplr_d  = b_neg ? -b : b;
          neg_d   = a_neg ^ b_neg;
          acc_d   = '0;
          count_d = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d   = shifted[2*WIDTH:WIDTH];
        mplr_d  = shifted[WIDTH-1:0];
        count_d = count_q + 1'b1;
        if (count_q == LAST) begin
          p_d         = neg_q ? -prod : prod;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      mplr_q      <= '0;
      mag_a_q     <= '0;
      neg_q       <= 1'b0;
      count_q     <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mplr_q      <= mplr_d;
      mag_a_q     <= mag_a_d;
      neg_q       <= neg_d;
      count_q     <= count_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_mul_iter.sv
// tb_mul_iter: directed checks of mul_iter at WIDTH=8 and WIDTH=16, plus a
// short randomised sweep against an integer reference product.

module tb_mul_iter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic        in_valid8, in_ready8, is_signed8, out_valid8, out_ready8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  mul_iter #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .is_signed(is_signed8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .p(p8)
  );

  // WIDTH=16 instance
  logic        in_valid16, in_ready16, is_signed16, out_valid16, out_ready16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  mul_iter #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .is_signed(is_signed16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .p(p16)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one WIDTH=8 operation, check latency and product, then hold
  // out_ready low for 'stall' cycles before completing the handshake.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic s, input logic [15:0] exp, input int stall);
    int cyc;
    @(negedge clk);
    check({tag, " in_ready"}, 64'(in_ready8), 64'd1);
    a8 = a; b8 = b; is_signed8 = s; in_valid8 = 1'b1; out_ready8 = 1'b0;
    @(posedge clk);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      in_valid8 = 1'b0;
    end while (!out_valid8 && cyc < 60);
    check({tag, " latency"}, 64'(cyc), 64'd8);
    check({tag, " p"}, 64'(p8), 64'(exp));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (!out_valid8 || p8 !== exp || in_ready8) check({tag, " stall hold"}, {out_valid8, in_ready8, p8}, {1'b1, 1'b0, exp});
    end
    out_ready8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready8 = 1'b0;
    check({tag, " back to idle"}, {out_valid8, in_ready8}, 2'b01);
  endtask

  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [31:0] exp);
    int cyc;
    @(negedge clk);
    a16 = a; b16 = b; is_signed16 = s; in_valid16 = 1'b1; out_ready16 = 1'b0;
    @(posedge clk);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      in_valid16 = 1'b0;
    end while (!out_valid16 && cyc < 60);
    check({tag, " latency"}, 64'(cyc), 64'd16);
    check({tag, " p"}, 64'(p16), 64'(exp));
    out_ready16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready16 = 1'b0;
    check({tag, " back to idle"}, {out_valid16, in_ready16}, 2'b01);
  endtask

  initial begin
    int cyc;
    int acc_t[$];
    logic [7:0] ra, rb;
    logic rs;
    longint la, lb;
    logic [15:0] rexp;

    rst = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; is_signed8 = 1'b0; out_ready8 = 1'b0;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; is_signed16 = 1'b0; out_ready16 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset in_ready low", 64'(in_ready8), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset out_valid8", 64'(out_valid8), 64'd0);
    check("reset p8", 64'(p8), 64'd0);
    check("reset p16", 64'(p16), 64'd0);
    check("reset in_ready8", 64'(in_ready8), 64'd1);
    check("reset in_ready16", 64'(in_ready16), 64'd1);

    // directed WIDTH=8
    run8("u ff*ff",  8'hFF, 8'hFF, 1'b0, 16'hFE01, 0);
    run8("s 80*7f",  8'h80, 8'h7F, 1'b1, 16'hC080, 0);
    run8("s 80*80",  8'h80, 8'h80, 1'b1, 16'h4000, 0);
    run8("s ff*01",  8'hFF, 8'h01, 1'b1, 16'hFFFF, 0);
    run8("s ff*ff",  8'hFF, 8'hFF, 1'b1, 16'h0001, 0);
    run8("s 80*ff",  8'h80, 8'hFF, 1'b1, 16'h0080, 0);
    run8("s 7f*7f",  8'h7F, 8'h7F, 1'b1, 16'h3F01, 0);
    run8("u 00*5a",  8'h00, 8'h5A, 1'b0, 16'h0000, 0);
    run8("u 80*80",  8'h80, 8'h80, 1'b0, 16'h4000, 0);
    run8("s 05*fd",  8'h05, 8'hFD, 1'b1, 16'hFFF1, 3);

    // back-pressure with ignored requests
    @(negedge clk);
    a8 = 8'h0C; b8 = 8'h0D; is_signed8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    cyc = 0;
    while (!out_valid8 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check("bp out_valid", 64'(out_valid8), 64'd1);
    check("bp p", 64'(p8), 64'h009C);
    for (int i = 0; i < 20; i++) begin
      a8 = 8'hAA ^ 8'(i); b8 = 8'h55; is_signed8 = 1'b1; in_valid8 = i[0];
      @(negedge clk);
      if (!out_valid8 || p8 !== 16'h009C || in_ready8)
        check("bp hold", {out_valid8, in_ready8, p8}, {1'b1, 1'b0, 16'h009C});
    end
    in_valid8 = 1'b0;
    check("bp held out_valid", 64'(out_valid8), 64'd1);
    check("bp held in_ready", 64'(in_ready8), 64'd0);
    out_ready8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready8 = 1'b0;
    check("bp release idle", {out_valid8, in_ready8}, 2'b01);
    check("bp p kept", 64'(p8), 64'h009C);
    run8("u 12*34 after bp", 8'h12, 8'h34, 1'b0, 16'h03A8, 0);

    // reset mid-CALC
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h44; is_signed8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst mid out_valid", 64'(out_valid8), 64'd0);
    check("rst mid p", 64'(p8), 64'd0);
    check("rst mid in_ready", 64'(in_ready8), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("after rst in_ready", 64'(in_ready8), 64'd1);
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid8) cyc++;
    end
    check("no stale result", 64'(cyc), 64'd0);
    run8("u 33*44 after rst", 8'h33, 8'h44, 1'b0, 16'h0D8C, 0);

    // WIDTH=16
    run16("w16 u ffff*ffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
    run16("w16 s ffff*ffff", 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001);
    run16("w16 s 8000*8000", 16'h8000, 16'h8000, 1'b1, 32'h40000000);

    // WIDTH=16 back-to-back spacing
    @(negedge clk);
    a16 = 16'hFFFF; b16 = 16'hFFFF; is_signed16 = 1'b1; in_valid16 = 1'b1; out_ready16 = 1'b1;
    cyc = 0;
    while (acc_t.size() < 3 && cyc < 100) begin
      if (in_ready16) acc_t.push_back(cyc);
      if (out_valid16 && p16 !== 32'h1) check("b2b p", 64'(p16), 64'h1);
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    in_valid16 = 1'b0;
    check("b2b accepts", 64'(acc_t.size()), 64'd3);
    if (acc_t.size() == 3) begin
      check("b2b spacing 1", 64'(acc_t[1] - acc_t[0]), 64'd18);
      check("b2b spacing 2", 64'(acc_t[2] - acc_t[1]), 64'd18);
    end
    while (!in_ready16 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    out_ready16 = 1'b0;

    // randomised WIDTH=8 sweep against integer reference
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      la = rs ? longint'($signed(ra)) : longint'(ra);
      lb = rs ? longint'($signed(rb)) : longint'(rb);
      rexp = 16'(la * lb);
      run8("rand8", ra, rb, rs, rexp, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mul_iter.md
# mul_iter

Parametrised iterative shift-add multiplier with valid/ready handshakes on input and output, and per-operation signed/unsigned selection. It is the area-optimised, sequential successor to the fixed 8x8 combinational Dadda multiplier. It serves datapaths that tolerate a WIDTH-cycle latency in exchange for one adder of WIDTH+1 bits instead of a full reduction tree.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands; high only in IDLE and while rst is low.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- is_signed  input  1  1: a, b and p are two's complement; 0: unsigned.
- out_valid  output  1  p holds a completed product.
- out_ready  input  1  consumer accepts p.
- p  output  2*WIDTH  product, registered.

Reset behaviour:
- One clock, clk; reset rst is synchronous and active-high.
- At reset: state=IDLE, out_valid=0, p=0, and all internal registers are 0.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid && in_ready at a clock edge:
    - mag_a=|a| and mag_b=|b| when is_signed; otherwise the raw values. Each fits WIDTH bits unsigned, including -2^(WIDTH-1).
    - neg = is_signed && (a[MSB] ^ b[MSB]).
    - acc (WIDTH+1 bits) = 0.
    - mplr = mag_b.
    - count = 0.
    - Next state: CALC.
- CALC (one iteration per cycle):
  - sum = acc + (mplr[0] ? mag_a : 0).
  - {acc, mplr} = {sum, mplr} >> 1.
  - count++.
  - After the iteration with count == WIDTH-1, load p = neg ? -{acc,mplr} : {acc,mplr}, negated in 2*WIDTH bits with wrap-around. Set out_valid=1 and go to DONE.
- DONE:
  - out_valid=1 and p is held stable.
  - On out_valid && out_ready: clear out_valid and go to IDLE. p keeps its last value.
- Inputs a, b, is_signed and in_valid are ignored outside IDLE. Operands are captured only at the accept edge, so changing them mid-operation has no effect.
- Arithmetic rules:
  - Unsigned results are exact in 2*WIDTH bits.
  - Signed results are exact two's complement in 2*WIDTH bits, including (-2^(W-1))*(-2^(W-1)) = 2^(2W-2).
  - A zero operand still takes the full WIDTH iterations; there is no early termination.
- Reset mid-operation (any state): next edge goes to IDLE with out_valid=0 and p=0. Any in-flight result is discarded.
- out_valid, once set, never drops without an out_ready handshake, except on rst.

## Timing
- Accept edge E0; CALC iterations at edges E1..EW.
- out_valid rises after edge EW, so latency is WIDTH cycles from accept to out_valid.
- With out_ready held high, out_valid lasts one cycle and the block is in IDLE after EW+1.
- Next accept can occur at EW+2, giving a maximum throughput of one operation per WIDTH+2 cycles.
- No overlap: in_ready is 0 throughout CALC and DONE.
- Back-pressure: out_ready low in DONE stalls indefinitely with p stable.
- in_ready is combinational from the state register and rst. p and out_valid are registered.
- The critical path is one WIDTH+1-bit adder plus the 2*WIDTH-bit negation at the DONE load.

## Test plan
- WIDTH=8, unsigned: a=0xFF, b=0xFF, is_signed=0 -> out_valid exactly 8 cycles after accept, p=0xFE01.
- WIDTH=8, signed, sign-mix: a=0x80 (-128), b=0x7F -> p=0xC080; a=0x80, b=0x80 -> p=0x4000; a=0xFF, b=0x01 -> p=0xFFFF.
- Back-pressure: hold out_ready=0 for 20 cycles after out_valid -> p and out_valid stable, in_ready=0, and in_valid pulses with new operands are ignored. Then assert out_ready=1 -> IDLE next cycle, and the next accept yields the correct product of the new operands.
- Reset mid-CALC: assert rst 3 cycles after accept -> next edge out_valid=0, p=0, in_ready=1 after rst drops, and no stale result appears.
- WIDTH=16: a=0xFFFF, b=0xFFFF unsigned -> p=0xFFFE0001 after 16 cycles; signed -> p=0x00000001. Back-to-back with out_ready=1 -> accepts spaced exactly 18 cycles.
- Random regression: 10k random a, b, is_signed per WIDTH in {2,8,13,32} against a behavioural reference product, with random out_ready stalls.
